// File: rtl/sram_pkg.sv
// Shared SRAM-side constants for the stream FIFO and its neighbours.
//   SRAM_AW         : SRAM word-address width
//   SRAM_DW         : SRAM data width
//   SRAM_RD_LATENCY : cycles from read issue to valid data (only 1 is supported)
//   op_e            : kind of the most recent SRAM operation
package sram_pkg;

  localparam int unsigned SRAM_AW         = 19;
  localparam int unsigned SRAM_DW         = 8;
  localparam int unsigned SRAM_RD_LATENCY = 1;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } op_e;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry valid/ready skid buffer with explicit push/pop and occupancy count.
//   clk_i       : clock
//   rst_ni      : synchronous reset, active-low
//   push_i      : write push_data_i into the tail this cycle
//   push_data_i : data to push
//   pop_i       : consumer ready; pops the head when valid_o is high
//   valid_o     : buffer holds at least one entry
//   data_o      : head entry
//   count_o     : number of entries held (0..2)
module stream_skid2 #(
  parameter int unsigned dw = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [dw-1:0] push_data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [dw-1:0] data_o,
  output logic [1:0]    count_o
);

  logic [dw-1:0] head_q, head_d;
  logic [dw-1:0] tail_q, tail_d;
  logic [1:0]    count_q, count_d;
  logic          do_pop, do_push;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_pop  = pop_i && (count_q != 2'd0);
    // A push into a full buffer is only accepted when the head leaves the same cycle.
    do_push = push_i && ((count_q != 2'd2) || do_pop);

    unique case ({do_push, do_pop})
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data_i;
        else                 tail_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/sram_stream_fifo.sv
// Deep stream FIFO whose storage is the external single-port SRAM (via the arbiter).
// Writes from s_* go to a wrapping write pointer; words are prefetched from a wrapping
// read pointer into a 2-entry skid buffer that drives m_*.
//   clk, rst_n                     : clock, synchronous active-low reset
//   s_data/s_valid/s_ready         : write-side stream (handshake == SRAM write issue)
//   m_data/m_valid/m_ready         : read-side stream (skid head)
//   level                          : words accepted and not yet delivered
//   mem_addr/mem_data_wr/mem_en/mem_we : SRAM request, combinational
//   mem_busy                       : arbiter busy, blocks all issues
//   mem_data_rd/mem_valid          : read return, one cycle after a read issue
module sram_stream_fifo
  import sram_pkg::*;
#(
  parameter int unsigned aw = SRAM_AW,
  parameter int unsigned dw = SRAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [dw-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [dw-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [aw:0]   level,
  output logic [aw-1:0] mem_addr,
  output logic [dw-1:0] mem_data_wr,
  output logic          mem_en,
  output logic          mem_we,
  input  logic          mem_busy,
  input  logic [dw-1:0] mem_data_rd,
  input  logic          mem_valid
);

  typedef logic [aw:0] cnt_t;

  localparam cnt_t Depth = {1'b1, {aw{1'b0}}};

  logic [aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [aw-1:0] rd_ptr_q, rd_ptr_d;
  cnt_t          occ_q, occ_d;
  logic          rd_inflight_q, rd_inflight_d;
  op_e           last_op_q, last_op_d;

  logic          wr_cand, rd_cand, do_wr, do_rd, rd_return;
  logic          skid_valid;
  logic [dw-1:0] skid_head;
  logic [1:0]    skid_count;

  // Issue scheduler: at most one SRAM op per cycle, alternating when both sides want it.
  // Candidates are gated by rst_n so the request outputs are quiet while reset is held.
  always_comb begin
    wr_cand = rst_n && s_valid && (occ_q != Depth) && !mem_busy;
    // Only prefetch when the skid is guaranteed room for the returning word.
    rd_cand = rst_n && (occ_q != '0) && !mem_busy &&
              ((skid_count + {1'b0, rd_inflight_q}) < 2'd2);
    do_wr   = wr_cand;
    do_rd   = rd_cand;
    if (wr_cand && rd_cand) begin
      do_wr = (last_op_q == OpRead);
      do_rd = !do_wr;
    end
    // Read latency is fixed at one cycle (SRAM_RD_LATENCY), so a single flag suffices.
    rd_return = rd_inflight_q && mem_valid;
  end

  always_comb begin
    s_ready     = do_wr;
    mem_en      = do_wr || do_rd;
    mem_we      = do_wr;
    mem_addr    = '0;
    mem_data_wr = '0;
    if (do_wr) begin
      mem_addr    = wr_ptr_q;
      mem_data_wr = s_data;
    end else if (do_rd) begin
      mem_addr = rd_ptr_q;
    end
    m_valid = rst_n && skid_valid;
    m_data  = rst_n ? skid_head : '0;
    // Fits in aw+1 bits for aw >= 2 (max DEPTH+2).
    level   = rst_n ? (occ_q + cnt_t'(rd_inflight_q) + cnt_t'(skid_count)) : '0;
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    rd_inflight_d = rd_inflight_q;
    last_op_d     = last_op_q;
    if (rd_return) rd_inflight_d = 1'b0;
    if (do_wr) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      occ_d     = occ_q + 1'b1;
      last_op_d = OpWrite;
    end
    if (do_rd) begin
      rd_ptr_d      = rd_ptr_q + 1'b1;
      occ_d         = occ_q - 1'b1;
      rd_inflight_d = 1'b1;
      last_op_d     = OpRead;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      rd_inflight_q <= 1'b0;
      last_op_q     <= OpRead;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      rd_inflight_q <= rd_inflight_d;
      last_op_q     <= last_op_d;
    end
  end

  stream_skid2 #(
    .dw (dw)
  ) u_skid (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (rd_return),
    .push_data_i (mem_data_rd),
    .pop_i       (m_ready),
    .valid_o     (skid_valid),
    .data_o      (skid_head),
    .count_o     (skid_count)
  );

endmodule

// File: tb/tb_sram_stream_fifo.sv
module tb_sram_stream_fifo;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW:0]   level;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_wr;
  logic          mem_en;
  logic          mem_we;
  logic          mem_busy = 1'b0;
  logic [DW-1:0] mem_data_rd;
  logic          mem_valid;

  always #5 clk = ~clk;

  sram_stream_fifo #(
    .aw (AW),
    .dw (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .level       (level),
    .mem_addr    (mem_addr),
    .mem_data_wr (mem_data_wr),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_busy    (mem_busy),
    .mem_data_rd (mem_data_rd),
    .mem_valid   (mem_valid)
  );

  // Behavioural 1-cycle SRAM behind the arbiter; deliberately not reset.
  logic [DW-1:0] sram [DEPTH];
  logic          rd_valid_r = 1'b0;
  logic [DW-1:0] rd_data_r = '0;
  logic          spurious = 1'b0;

  always @(posedge clk) begin
    if (mem_en && !mem_busy && mem_we) sram[mem_addr] <= mem_data_wr;
    rd_valid_r <= mem_en && !mem_busy && !mem_we;
    rd_data_r  <= sram[mem_addr];
  end

  assign mem_valid   = rd_valid_r | spurious;
  assign mem_data_rd = rd_data_r;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard and reference pointers.
  logic [DW-1:0] exp_q[$];
  int acc = 0;
  int dlv = 0;
  int wp = 0;
  int rp = 0;

  task automatic clear_model();
    exp_q.delete();
    acc = 0;
    dlv = 0;
    wp  = 0;
    rp  = 0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    mem_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_model();
  endtask

  // One cycle of streaming with scoreboard, pointer and level checks.
  task automatic run_cycle(input logic sv, input logic [DW-1:0] sd, input logic mr,
                           input logic bz, output logic hs);
    s_valid  = sv;
    s_data   = sd;
    m_ready  = mr;
    mem_busy = bz;
    @(negedge clk);
    chk("level", int'(level), acc - dlv);
    if (bz) chk("busy_no_issue", int'(mem_en), 0);
    if (mem_en && mem_we) begin
      chk("wr_addr", int'(mem_addr), wp);
      wp = (wp + 1) % DEPTH;
    end
    if (mem_en && !mem_we) begin
      chk("rd_addr", int'(mem_addr), rp);
      rp = (rp + 1) % DEPTH;
    end
    hs = sv && s_ready;
    if (hs) begin
      exp_q.push_back(sd);
      acc++;
    end
    if (m_valid && mr) begin
      if (exp_q.size() == 0) begin
        chk("m_unexpected_word", int'(m_data), -1);
      end else begin
        chk("m_data_order", int'(m_data), int'(exp_q.pop_front()));
      end
      dlv++;
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: m_ready=1, mode 1: toggling 1,0,..., mode 2: m_ready=0.
  task automatic stream(input int first, input int count, input int mode, input int busy_at,
                        input int max_cycles, output int accepted);
    logic hs;
    logic mr;
    int   idx;
    idx = 0;
    for (int c = 0; c < max_cycles; c++) begin
      mr = (mode == 0) ? 1'b1 : ((mode == 1) ? (c % 2 == 0) : 1'b0);
      run_cycle(idx < count, 8'(first + idx), mr, (c >= busy_at) && (c < busy_at + 5), hs);
      if (hs) idx++;
      if (mode != 2 && idx == count && acc == dlv) break;
    end
    accepted = idx;
  endtask

  typedef struct packed {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          e_sr;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_mv;
    logic [DW-1:0] e_md;
    logic [AW:0]   e_lvl;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int  n;
    logic hs;

    // Single word then a 3-word burst with interleaved W/R issues.
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'hA5, 1'b0, 8'h00, 5'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 5'd1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 5'd1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 8'hA5, 5'd1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 5'd0};
    vecs[5]  = '{1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 8'h10, 1'b0, 8'h00, 5'd0};
    vecs[6]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 8'h00, 5'd1};
    vecs[7]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 8'h11, 1'b0, 8'h00, 5'd1};
    vecs[8]  = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 8'h10, 5'd2};
    vecs[9]  = '{1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 8'h12, 1'b0, 8'h00, 5'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 8'h11, 5'd2};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 5'd1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 8'h12, 5'd1};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 5'd0};

    // Reset held 3 cycles with s_valid=1.
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_s_ready", int'(s_ready), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_mem_en", int'(mem_en), 0);
      chk("rst_level", int'(level), 0);
    end
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    s_valid = 1'b0;

    for (int i = 0; i < 14; i++) begin
      s_valid  = vecs[i].sv;
      s_data   = vecs[i].sd;
      m_ready  = vecs[i].mr;
      mem_busy = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_s_ready", i), int'(s_ready), int'(vecs[i].e_sr));
      chk($sformatf("v%0d_mem_en", i), int'(mem_en), int'(vecs[i].e_en));
      chk($sformatf("v%0d_mem_we", i), int'(mem_we), int'(vecs[i].e_we));
      if (vecs[i].e_en) chk($sformatf("v%0d_mem_addr", i), int'(mem_addr), int'(vecs[i].e_addr));
      if (vecs[i].e_we) chk($sformatf("v%0d_mem_wdata", i), int'(mem_data_wr), int'(vecs[i].e_wd));
      chk($sformatf("v%0d_m_valid", i), int'(m_valid), int'(vecs[i].e_mv));
      if (vecs[i].e_mv) chk($sformatf("v%0d_m_data", i), int'(m_data), int'(vecs[i].e_md));
      chk($sformatf("v%0d_level", i), int'(level), int'(vecs[i].e_lvl));
      @(posedge clk);
      #1;
    end

    // Fill to full with m_ready=0, then drain in order.
    do_reset();
    stream(8'h00, 22, 2, 1000, 80, n);
    chk("fill_accepted", n, 18);
    s_valid = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("full_s_ready", int'(s_ready), 0);
    chk("full_mem_en", int'(mem_en), 0);
    chk("full_level", int'(level), 18);
    @(posedge clk);
    #1;
    for (int c = 0; c < 100 && acc != dlv; c++) run_cycle(1'b0, 8'h00, 1'b1, 1'b0, hs);
    chk("fill_delivered", dlv, 18);
    chk("fill_level_end", int'(level), 0);

    // 40 words, pointers wrap twice, m_ready toggling.
    do_reset();
    stream(8'h00, 40, 1, 1000, 600, n);
    chk("wrap_accepted", n, 40);
    chk("wrap_delivered", dlv, 40);
    chk("wrap_wr_ptr", wp, 40 % DEPTH);
    chk("wrap_rd_ptr", rp, 40 % DEPTH);

    // mem_busy for 5 cycles mid-stream.
    do_reset();
    stream(8'h40, 20, 0, 6, 300, n);
    chk("busy_accepted", n, 20);
    chk("busy_delivered", dlv, 20);

    // Reset in the cycle after a read issue; stale and spurious mem_valid ignored.
    do_reset();
    run_cycle(1'b1, 8'h77, 1'b0, 1'b0, hs);
    chk("rmid_write_hs", int'(hs), 1);
    s_valid = 1'b0;
    @(negedge clk);
    chk("rmid_read_issue", int'(mem_en && !mem_we), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmid_rst_mem_valid_seen", int'(mem_valid), 1);
    chk("rmid_rst_m_valid", int'(m_valid), 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    spurious = 1'b1;
    @(negedge clk);
    chk("rmid_level_after", int'(level), 0);
    @(posedge clk);
    #1;
    spurious = 1'b0;
    m_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rmid_m_valid", int'(m_valid), 0);
      chk("rmid_level", int'(level), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
